enigma_letter_decoder: RTL and testbench

Receive-side companion to the `enigma` cipher core. It tracks which core output cycles carry a real letter using a valid delay line matched to the core's fixed latency, and converts each 26-bit one-hot cipher letter to 8-bit ASCII with a one-hot legality check. Results are buffered in a small FIFO and delivered on a ready/valid stream. It sits between the core's `output_letter` and the downstream text sink, and issues credit back to the letter source so the FIFO never overflows in normal use.

---
 rtl/enigma_pkg.sv | 35 +++
 rtl/enigma_sync_fifo.sv | 74 +++++++
 rtl/enigma_letter_decoder.sv | 111 +++++++++++
 tb/tb_enigma_letter_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared types and helpers for the enigma receive path: letter/ASCII types,
// ASCII constants and the one-hot letter index decoder.
package enigma_pkg;

   localparam int ALPHABET = 26;

   typedef logic [ALPHABET-1:0] letter_t;
   typedef logic [7:0]          ascii_t;

   localparam ascii_t ASCII_UPPER_A = 8'h41;
   localparam ascii_t ASCII_LOWER_A = 8'h61;
   localparam ascii_t ASCII_ERR     = 8'h3F;

   // One buffered result: error flag above the character.
   typedef struct packed {
      logic   err;
      ascii_t data;
   } fifo_entry_t;

   // Returns {legal, index}; legal only when exactly one bit is set.
   function automatic logic [5:0] onehot_to_index(input letter_t l);
      logic [4:0] idx;
      int         cnt;
      idx = '0;
      cnt = 0;
      for (int i = 0; i < ALPHABET; i++) begin
         if (l[i]) begin
            idx = 5'(i);
            cnt++;
         end
      end
      return {(cnt == 1), idx};
   endfunction

endpackage

// File: rtl/enigma_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head: the output holds its
// last value while empty, and a push while full without a pop is dropped.
module enigma_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             full, empty, pop_ok, wr_en;

   assign full   = (count_q == (AW+1)'(DEPTH));
   assign empty  = (count_q == '0);
   assign pop_ok = pop && !empty;
   assign wr_en  = push && (!full || pop_ok);
   assign drop   = push && full && !pop_ok;

   always_comb begin
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      count_d  = count_q;
      if (wr_en && !pop_ok)
         count_d = count_q + 1'b1;
      else if (!wr_en && pop_ok)
         count_d = count_q - 1'b1;
      // The next head may be the very entry being written this cycle.
      head_d = head_q;
      if (count_d != '0) begin
         if (wr_en && (rd_ptr_d == wr_ptr_q))
            head_d = wdata;
         else
            head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign rdata = head_q;
   assign valid = !empty;
   assign level = count_q;

endmodule

// File: rtl/enigma_letter_decoder.sv
// Receive-side letter decoder: tracks valid core output cycles, converts
// one-hot cipher letters to ASCII, buffers them and grants source credit.
module enigma_letter_decoder
   import enigma_pkg::*;
#(
   parameter int CORE_LATENCY = 4,
   parameter int FIFO_DEPTH   = 8,
   parameter bit UPPER_CASE   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          issue_valid,
   output logic                          credit_ok,
   input  letter_t                       core_letter,
   output logic                          m_valid,
   input  logic                          m_ready,
   output ascii_t                        m_data,
   output logic                          m_err,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   output logic [15:0]                   err_count
);

   localparam ascii_t BASE = UPPER_CASE ? ASCII_UPPER_A : ASCII_LOWER_A;
   localparam int     IW   = $clog2(CORE_LATENCY + 1);
   localparam int     LW   = $clog2(FIFO_DEPTH) + 1;

   logic [CORE_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
   logic [IW-1:0]           inflight_q, inflight_d;
   logic [15:0]             err_cnt_q, err_cnt_d;
   logic                    overflow_q, overflow_d;
   logic                    tap, legal, drop;
   logic [5:0]              idx_w;
   fifo_entry_t             wr_entry, rd_entry;

   generate
      if (CORE_LATENCY == 1) begin : g_pipe1
         assign vld_pipe_d = issue_valid;
      end else begin : g_pipen
         assign vld_pipe_d = {vld_pipe_q[CORE_LATENCY-2:0], issue_valid};
      end
   endgenerate

   assign tap = vld_pipe_q[CORE_LATENCY-1];

   always_comb begin
      inflight_d = inflight_q;
      case ({issue_valid, tap})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   assign idx_w = onehot_to_index(core_letter);
   assign legal = idx_w[5];

   always_comb begin
      wr_entry.err  = !legal;
      wr_entry.data = legal ? (BASE + ascii_t'(idx_w[4:0])) : ASCII_ERR;
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (tap && !legal && (err_cnt_q != 16'hFFFF))
         err_cnt_d = err_cnt_q + 16'd1;
   end

   assign overflow_d = overflow_q | drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         inflight_q <= '0;
         err_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         inflight_q <= inflight_d;
         err_cnt_q  <= err_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   enigma_sync_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tap),
      .wdata (wr_entry),
      .pop   (m_valid && m_ready),
      .rdata (rd_entry),
      .valid (m_valid),
      .level (level),
      .drop  (drop)
   );

   // Room left must cover letters already buffered plus those still in the core.
   assign credit_ok = (32'(level) + 32'(inflight_q)) < 32'(FIFO_DEPTH);

   assign m_data    = rd_entry.data;
   assign m_err     = rd_entry.err;
   assign overflow  = overflow_q;
   assign err_count = err_cnt_q;

   logic unused_lw;
   assign unused_lw = ^LW;

endmodule

// File: tb/tb_enigma_letter_decoder.sv
// Directed bench for enigma_letter_decoder with a latency-matched core model
// and an in-order scoreboard of expected {err, ascii} results.
module tb_enigma_letter_decoder;
   import enigma_pkg::*;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       issue_valid = 1'b0;
   logic       m_ready = 1'b0;
   letter_t    letter_in = '0;
   letter_t    lp [4];
   letter_t    core_letter;

   logic       credit_ok, m_valid, m_err, overflow;
   ascii_t     m_data;
   logic [3:0] level;
   logic [15:0] err_count;

   logic       c2_ok, m2_valid, m2_err, ov2;
   ascii_t     m2_data;
   logic [3:0] level2;
   logic [15:0] ec2;

   // Stand-in core: fixed 4-cycle delay, identity cipher.
   assign core_letter = lp[3];
   always @(posedge clk) begin
      lp[0] <= letter_in;
      for (int i = 1; i < 4; i++) lp[i] <= lp[i-1];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   enigma_letter_decoder #(.CORE_LATENCY(4), .FIFO_DEPTH(8), .UPPER_CASE(1'b1)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .credit_ok(credit_ok),
      .core_letter(core_letter), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_err(m_err), .level(level), .overflow(overflow),
      .err_count(err_count));

   enigma_letter_decoder #(.CORE_LATENCY(4), .FIFO_DEPTH(8), .UPPER_CASE(1'b0)) dut_lc (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .credit_ok(c2_ok),
      .core_letter(core_letter), .m_valid(m2_valid), .m_ready(1'b1),
      .m_data(m2_data), .m_err(m2_err), .level(level2), .overflow(ov2),
      .err_count(ec2));

   typedef struct {
      logic [8:0] ent;
      int         cyc;
   } exp_t;

   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;
   int   npop   = 0;
   bit   strict = 1'b0;

   function automatic logic [8:0] expect_of(letter_t l);
      if ($countones(l) == 1)
         return {1'b0, 8'h41 + 8'($clog2(l))};
      return {1'b1, 8'h3F};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      if (m_valid === 1'b1 && m_ready) begin
         npop++;
         if (sb.size() == 0) begin
            chk("unexpected_pop", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("m_data", 32'(m_data), 32'(e.ent[7:0]));
            chk("m_err", 32'(m_err), 32'(e.ent[8]));
            if (strict) chk("latency", 32'(cyc - e.cyc), 32'd5);
         end
      end
   endtask

   // Inputs change at posedge+1, outputs are compared at the negedge.
   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic issue(input letter_t l, input bit keep);
      exp_t e;
      issue_valid = 1'b1;
      letter_in   = l;
      if (keep) begin
         e.ent = expect_of(l);
         e.cyc = cyc;
         sb.push_back(e);
      end
      tick();
      issue_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int p0;

      // Reset state after the first edge with rst high
      @(posedge clk); #1;
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_credit", 32'(credit_ok), 1);
      chk("rst_errcnt", 32'(err_count), 0);
      tick();
      rst = 1'b0;

      // Single letters, issue at cycle 10
      strict  = 1'b1;
      m_ready = 1'b1;
      while (cyc < 10) tick();
      issue(letter_t'(1), 1'b1);
      ticks(3);
      chk("single_not_early", 32'(m_valid), 0);
      ticks(1);
      chk("single_cycle", 32'(cyc), 15);
      chk("single_valid", 32'(m_valid), 1);
      chk("single_A", 32'(m_data), 32'h41);
      chk("single_lower_a", 32'(m2_data), 32'h61);
      tick();
      issue(letter_t'(1) << 25, 1'b1);
      ticks(5);
      chk("single_Z", 32'(m_data), 32'h5A);
      chk("single_lower_z", 32'(m2_data), 32'h7A);
      tick();

      // Illegal letters
      issue(letter_t'(0), 1'b1);
      issue(letter_t'(3), 1'b1);
      ticks(6);
      chk("illegal_cnt", 32'(err_count), 2);
      chk("empty_valid", 32'(m_valid), 0);
      chk("empty_hold_data", 32'(m_data), 32'h3F);
      chk("empty_hold_err", 32'(m_err), 1);

      // Error counter saturation
      force dut.err_cnt_q = 16'hFFFE;
      #1;
      release dut.err_cnt_q;
      chk("force_errcnt", 32'(err_count), 32'hFFFE);
      issue(letter_t'(0), 1'b1);
      issue('1, 1'b1);
      issue(letter_t'(5), 1'b1);
      ticks(6);
      chk("errcnt_sat", 32'(err_count), 32'hFFFF);

      // Backpressure: credit must stop the source at exactly 8
      strict  = 1'b0;
      m_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (credit_ok) begin
            issue(letter_t'(1) << n, 1'b1);
            n++;
         end else begin
            tick();
         end
      end
      chk("bp_issued", 32'(n), 8);
      chk("bp_level", 32'(level), 8);
      chk("bp_credit", 32'(credit_ok), 0);
      chk("bp_overflow", 32'(overflow), 0);
      chk("bp_head", 32'(m_data), 32'h41);

      // Forced issue into a full FIFO is dropped
      issue(letter_t'(1) << 25, 1'b0);
      ticks(5);
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_level", 32'(level), 8);

      // Full plus a pop aligned with the tap: nothing dropped
      issue(letter_t'(1) << 24, 1'b1);
      ticks(3);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("align_level", 32'(level), 8);
      chk("ovf_sticky", 32'(overflow), 1);
      m_ready = 1'b1;
      p0 = npop;
      ticks(8);
      chk("drain_pops", 32'(npop - p0), 8);
      chk("drain_level", 32'(level), 0);
      chk("drain_sb", 32'(sb.size()), 0);

      // Streaming: 100 random legal letters, back to back
      strict = 1'b1;
      p0 = npop;
      for (int i = 0; i < 100; i++)
         issue(letter_t'(1) << $urandom_range(0, 25), 1'b1);
      ticks(6);
      chk("stream_pops", 32'(npop - p0), 100);
      chk("stream_sb", 32'(sb.size()), 0);

      // Reset with 4 buffered and 3 in flight
      strict  = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) issue(letter_t'(1) << i, 1'b1);
      ticks(5);
      chk("pre_rst_level", 32'(level), 4);
      for (int i = 4; i < 7; i++) issue(letter_t'(1) << i, 1'b1);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", 32'(m_valid), 0);
      chk("mid_rst_data", 32'(m_data), 0);
      chk("mid_rst_err", 32'(m_err), 0);
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_ovf", 32'(overflow), 0);
      chk("mid_rst_errcnt", 32'(err_count), 0);
      chk("mid_rst_credit", 32'(credit_ok), 1);
      sb.delete();
      rst     = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("no_stale", 32'(m_valid), 0);
         tick();
      end
      chk("post_rst_level", 32'(level), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
